// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point
// widen/accumulate datapath.
package fxp_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Largest positive two's-complement value of the given width.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fxp_widen.sv
// Combinational Q(WIO.WFO) -> Q(WIA.WFA) widening:
// sign-extend the integer part, zero-pad the fraction.
module fxp_widen #(
    parameter int WIO = 6,
    parameter int WFO = 11,
    parameter int WIA = 12,
    parameter int WFA = 16
) (
    input  logic [WIO+WFO-1:0] in_data,
    output logic [WIA+WFA-1:0] out_data
);

    localparam int WOUT = WIA + WFA;

    logic signed [WOUT-1:0] ext;

    // Sign-extend to full width, then shift the fraction into place;
    // the bits shifted out are copies of the sign, so the value is exact.
    always_comb begin
        ext      = WOUT'($signed(in_data));
        out_data = ext << (WFA - WFO);
    end

endmodule

// File: rtl/fxp_widen_accumulate.sv
// Widens narrowed samples and accumulates them per frame with a
// saturating adder; reports sum, sticky saturation and flag counts.
module fxp_widen_accumulate
    import fxp_pkg::*;
#(
    parameter int WIO       = 6,
    parameter int WFO       = 11,
    parameter int WIA       = 12,
    parameter int WFA       = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIO+WFO-1:0]               in_data,
    input  logic                             in_last,
    input  logic                             in_overflow,
    input  logic                             in_underflow,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIA+WFA-1:0]               out_sum,
    output logic [cnt_width(FRAME_LEN)-1:0]  out_count,
    output logic [cnt_width(FRAME_LEN)-1:0]  out_of_count,
    output logic [cnt_width(FRAME_LEN)-1:0]  out_uf_count,
    output logic                             out_acc_sat
);

    localparam int W  = WIA + WFA;
    localparam int CW = cnt_width(FRAME_LEN);

    localparam logic [W-1:0]  SMAX     = W'(sat_max(W));
    localparam logic [W-1:0]  SMIN     = W'(sat_min(W));
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    if (WIA < WIO || WFA < WFO || FRAME_LEN < 1) begin : g_bad_params
        $fatal(1, "fxp_widen_accumulate: illegal parameters");
    end

    state_t        state;
    logic [W-1:0]  acc;
    logic          sat;
    logic [CW-1:0] cnt;
    logic [CW-1:0] of_cnt;
    logic [CW-1:0] uf_cnt;

    logic [W-1:0]  wid;
    logic [W:0]    sum_ext;
    logic [W-1:0]  acc_nxt;
    logic          sat_hit;
    logic          accept;
    logic          frame_end;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] of_nxt;
    logic [CW-1:0] uf_nxt;

    fxp_widen #(
        .WIO (WIO),
        .WFO (WFO),
        .WIA (WIA),
        .WFA (WFA)
    ) u_widen (
        .in_data  (in_data),
        .out_data (wid)
    );

    assign in_ready = (state == ACCUM);

    // Saturating add one bit wider; top-two-bit mismatch means overflow.
    always_comb begin
        sum_ext = {acc[W-1], acc} + {wid[W-1], wid};
        acc_nxt = sum_ext[W-1:0];
        sat_hit = 1'b0;
        if (sum_ext[W] != sum_ext[W-1]) begin
            sat_hit = 1'b1;
            acc_nxt = sum_ext[W] ? SMIN : SMAX;
        end
    end

    // Accept/frame-end decode and next counter values.
    always_comb begin
        accept    = in_valid && in_ready;
        frame_end = accept && (in_last || cnt == LAST_CNT);
        cnt_nxt   = cnt + CW'(1);
        of_nxt    = of_cnt + CW'(in_overflow);
        uf_nxt    = uf_cnt + CW'(in_underflow);
    end

    // Frame FSM: accumulate until frame end, then hold the result
    // until the downstream takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            acc          <= '0;
            sat          <= 1'b0;
            cnt          <= '0;
            of_cnt       <= '0;
            uf_cnt       <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_of_count <= '0;
            out_uf_count <= '0;
            out_acc_sat  <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        acc    <= acc_nxt;
                        sat    <= sat | sat_hit;
                        cnt    <= cnt_nxt;
                        of_cnt <= of_nxt;
                        uf_cnt <= uf_nxt;
                        if (frame_end) begin
                            out_sum      <= acc_nxt;
                            out_count    <= cnt_nxt;
                            out_of_count <= of_nxt;
                            out_uf_count <= uf_nxt;
                            out_acc_sat  <= sat | sat_hit;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        sat       <= 1'b0;
                        cnt       <= '0;
                        of_cnt    <= '0;
                        uf_cnt    <= '0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
